// File: rtl/tdm_demux.sv
// ----------------------------------------------------------------------------
// tdm_demux
// Splits a serial TDM stream into CHANNELS parallel slot registers. Slot 0 is
// marked by frame_sync. A frame is acquired in HUNT and slots are then counted
// in RUN. Every beat that is written appears one cycle later on out_data, and
// its channel bit pulses on out_valid.
//
// Optional feature: define TDM_DEMUX_SYNC_CHECK_EN to check frame alignment in
// RUN. A missing sync at slot 0 sends the block back to HUNT. An early sync
// resyncs the block onto channel 0. Either case pulses sync_err. When the macro
// is not defined, sync_err is tied to 0 and RUN counts slots freely.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   in_data        slot payload (WIDTH bits)
//   in_valid       in_data carries a beat this cycle
//   frame_sync     the current beat is slot 0 (only meaningful with in_valid)
//   out_data       channel k held in bits [k*WIDTH +: WIDTH]
//   out_valid      one-cycle pulse on the bit of the channel just written
//   frame_done     one-cycle pulse when the last slot of a frame is written
//   sync_err       one-cycle framing-error pulse (only with the check enabled)
// ----------------------------------------------------------------------------
module tdm_demux #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned WIDTH    = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [WIDTH-1:0]             in_data,
   input  logic                         in_valid,
   input  logic                         frame_sync,
   output logic [CHANNELS*WIDTH-1:0]    out_data,
   output logic [CHANNELS-1:0]          out_valid,
   output logic                         frame_done,
   output logic                         sync_err
);

   localparam int unsigned CNT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(CHANNELS - 1);

   typedef enum logic {
      HUNT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                      state_q, state_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [CHANNELS*WIDTH-1:0]   data_d;
   logic [CHANNELS-1:0]         valid_d;
   logic                        done_d;
   logic                        wr_en;
   logic [CNT_W-1:0]            wr_sel;
   logic                        advance;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
   logic                        err_d;
`endif

   // Next-state, slot selection and next output values
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      wr_en   = 1'b0;
      wr_sel  = '0;
      advance = 1'b0;
      data_d  = out_data;
      valid_d = '0;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
      err_d   = 1'b0;
`endif

      if (in_valid) begin
         unique case (state_q)
            HUNT: begin
               if (frame_sync) begin
                  wr_en   = 1'b1;
                  wr_sel  = '0;
                  cnt_d   = CNT_W'(1);
                  state_d = RUN;
               end
            end
            RUN: begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
               if ((cnt_q == '0) && !frame_sync) begin
                  // Lost alignment: drop the beat and reacquire
                  err_d   = 1'b1;
                  cnt_d   = '0;
                  state_d = HUNT;
               end else if (frame_sync && (cnt_q != '0)) begin
                  // Early sync: abandon the partial frame and restart at slot 0
                  err_d   = 1'b1;
                  wr_en   = 1'b1;
                  wr_sel  = '0;
                  cnt_d   = CNT_W'(1);
               end else begin
                  advance = 1'b1;
               end
`else
               advance = 1'b1;
`endif
            end
            default: state_d = HUNT;
         endcase
      end

      // Normal in-frame write with wrap after the last slot
      if (advance) begin
         wr_en  = 1'b1;
         wr_sel = cnt_q;
         if (cnt_q == LAST_SLOT) begin
            done_d = 1'b1;
            cnt_d  = '0;
         end else begin
            cnt_d  = cnt_q + CNT_W'(1);
         end
      end

      for (int unsigned k = 0; k < CHANNELS; k++) begin
         if (wr_en && (wr_sel == CNT_W'(k))) begin
            data_d[k*WIDTH +: WIDTH] = in_data;
            valid_d[k]               = 1'b1;
         end
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= HUNT;
         cnt_q      <= '0;
         out_data   <= '0;
         out_valid  <= '0;
         frame_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         out_data   <= data_d;
         out_valid  <= valid_d;
         frame_done <= done_d;
      end
   end

`ifdef TDM_DEMUX_SYNC_CHECK_EN
   // Framing-error pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_err <= 1'b0;
      end else begin
         sync_err <= err_d;
      end
   end
`else
   assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// ----------------------------------------------------------------------------
// tb_tdm_demux
// Directed bench for tdm_demux (CHANNELS=4, WIDTH=8). A reference model runs
// alongside the stimulus. Each beat pushes its expected outputs onto a
// scoreboard queue, and those entries are popped and compared one edge later.
// It follows TDM_DEMUX_SYNC_CHECK_EN in the same way as the design.
// ----------------------------------------------------------------------------
module tb_tdm_demux;

   localparam int unsigned CH = 4;
   localparam int unsigned W  = 8;

   typedef struct packed {
      logic [CH-1:0]   valid;
      logic            done;
      logic            err;
      logic [CH*W-1:0] data;
   } exp_t;

   logic              clk;
   logic              rst_n;
   logic [W-1:0]      in_data;
   logic              in_valid;
   logic              frame_sync;
   logic [CH*W-1:0]   out_data;
   logic [CH-1:0]     out_valid;
   logic              frame_done;
   logic              sync_err;

   int passed;
   int total;
   int done_seen;

   exp_t            sb[$];
   logic [CH*W-1:0] m_data;
   int              m_cnt;
   bit              m_hunt;

   tdm_demux #(.CHANNELS(CH), .WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .frame_sync (frame_sync),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .frame_done (frame_done),
      .sync_err   (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_data = '0;
      m_cnt  = 0;
      m_hunt = 1'b1;
   endtask

   // Drive one cycle of stimulus, predict, then compare after the edge
   task automatic step(input logic v, input logic s, input logic [W-1:0] d);
      exp_t e;
      bit   wr;
      in_valid   = v;
      frame_sync = s;
      in_data    = d;
      e  = '0;
      wr = 1'b0;
      if (v) begin
         if (m_hunt) begin
            if (s) begin
               m_data[W-1:0] = d;
               e.valid       = 4'b0001;
               m_cnt         = 1;
               m_hunt        = 1'b0;
            end
         end else begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
            if (m_cnt == 0 && !s) begin
               e.err  = 1'b1;
               m_hunt = 1'b1;
            end else if (s && m_cnt != 0) begin
               e.err         = 1'b1;
               m_data[W-1:0] = d;
               e.valid       = 4'b0001;
               m_cnt         = 1;
            end else begin
               wr = 1'b1;
            end
`else
            wr = 1'b1;
`endif
         end
         if (wr) begin
            m_data[m_cnt*W +: W] = d;
            e.valid = 4'(1 << m_cnt);
            if (m_cnt == CH - 1) begin
               e.done = 1'b1;
               m_cnt  = 0;
            end else begin
               m_cnt++;
            end
         end
      end
      e.data = m_data;
      sb.push_back(e);

      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("out_valid",  64'(out_valid),  64'(e.valid));
      chk("frame_done", 64'(frame_done), 64'(e.done));
      chk("sync_err",   64'(sync_err),   64'(e.err));
      chk("out_data",   64'(out_data),   64'(e.data));
      if (frame_done) done_seen++;
   endtask

   // Asynchronous reset applied between clock edges, outputs checked at once
   task automatic async_reset(input string tag);
      in_valid   = 1'b0;
      frame_sync = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk({tag, "_data"},  64'(out_data),   64'd0);
      chk({tag, "_valid"}, 64'(out_valid),  64'd0);
      chk({tag, "_done"},  64'(frame_done), 64'd0);
      chk({tag, "_err"},   64'(sync_err),   64'd0);
      model_reset();
      #1 rst_n = 1'b1;
   endtask

   initial begin
      passed     = 0;
      total      = 0;
      done_seen  = 0;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      frame_sync = 1'b0;
      in_data    = '0;
      model_reset();

      // Power-on reset state
      #12;
      chk("por_data",  64'(out_data),   64'd0);
      chk("por_valid", 64'(out_valid),  64'd0);
      chk("por_done",  64'(frame_done), 64'd0);
      chk("por_err",   64'(sync_err),   64'd0);
      rst_n = 1'b1;

      // Reset in the middle of a frame, then an unsynced beat is ignored
      step(1'b1, 1'b1, 8'h11);
      step(1'b1, 1'b0, 8'h22);
      async_reset("midrst");
      step(1'b1, 1'b0, 8'hAA);
      chk("hunt_no_valid", 64'(out_valid), 64'd0);
      step(1'b0, 1'b1, 8'hBB);

      // Basic back-to-back frame
      step(1'b1, 1'b1, 8'h11);
      step(1'b1, 1'b0, 8'h22);
      step(1'b1, 1'b0, 8'h33);
      step(1'b1, 1'b0, 8'h44);
      chk("basic_data", 64'(out_data), 64'h44332211);

      // The same frame with idle gaps
      step(1'b1, 1'b1, 8'h11);
      step(1'b0, 1'b0, 8'hEE);
      step(1'b1, 1'b0, 8'h22);
      step(1'b0, 1'b1, 8'hEE);
      step(1'b0, 1'b0, 8'hEE);
      step(1'b1, 1'b0, 8'h33);
      step(1'b0, 1'b0, 8'hEE);
      step(1'b1, 1'b0, 8'h44);
      chk("gap_data", 64'(out_data), 64'h44332211);

      // Two consecutive frames with a counter wrap
      done_seen = 0;
      step(1'b1, 1'b1, 8'h11);
      step(1'b1, 1'b0, 8'h22);
      step(1'b1, 1'b0, 8'h33);
      step(1'b1, 1'b0, 8'h44);
      step(1'b1, 1'b1, 8'h55);
      step(1'b1, 1'b0, 8'h66);
      step(1'b1, 1'b0, 8'h77);
      step(1'b1, 1'b0, 8'h88);
      chk("wrap_data", 64'(out_data), 64'h88776655);
      chk("wrap_done_count", 64'(done_seen), 64'd2);

      // Missing sync at the start of the next frame
      step(1'b1, 1'b0, 8'h99);
`ifdef TDM_DEMUX_SYNC_CHECK_EN
      chk("miss_err",  64'(sync_err), 64'd1);
      chk("miss_data", 64'(out_data), 64'h88776655);
      step(1'b1, 1'b0, 8'hAB);
      chk("miss_hunt", 64'(out_valid), 64'd0);
`else
      chk("free_data", 64'(out_data), 64'h88776699);
`endif

      // Early sync on the third beat
      async_reset("prersync");
      done_seen = 0;
      step(1'b1, 1'b1, 8'h12);
      step(1'b1, 1'b0, 8'h34);
      step(1'b1, 1'b1, 8'hC0);
`ifdef TDM_DEMUX_SYNC_CHECK_EN
      chk("early_err", 64'(sync_err), 64'd1);
      chk("early_ch0", 64'(out_data[W-1:0]), 64'hC0);
      step(1'b1, 1'b0, 8'h56);
      chk("early_no_done", 64'(done_seen), 64'd0);
`else
      chk("early_no_err", 64'(sync_err), 64'd0);
      chk("early_ch2", 64'(out_data[2*W +: W]), 64'hC0);
      step(1'b1, 1'b0, 8'h56);
      chk("early_done", 64'(done_seen), 64'd1);
`endif
      step(1'b0, 1'b0, 8'h00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
